mbed_uart_tx: RTL and testbench

- Serial transmitter for the `serial_return` link back to the mbed.
- Complements the existing `serial_receive` path: the top-level FSM pushes status/acknowledge bytes, and the block buffers and sends them as 8N1 asynchronous serial frames.
- Sits between `top_level_fsm` and the `serial_return` pin, on the `clk50m` domain.

---
 rtl/mbed_uart_tx_pkg.sv | 25 ++
 rtl/mbed_uart_tx_if.sv | 19 +
 rtl/mbed_uart_tx_byte_fifo.sv | 68 ++++++
 rtl/mbed_uart_tx.sv | 140 ++++++++++++++
 tb/tb_mbed_uart_tx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mbed_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// mbed_uart_tx_pkg
// Shared serial-link definitions for the mbed transmit and receive paths:
// FSM state encoding, frame constants and the bit-period divisor calculation.
// No ports (package).
// -----------------------------------------------------------------------------
package mbed_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Bit period in clock cycles; integer truncation is intentional.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/mbed_uart_tx_if.sv
// -----------------------------------------------------------------------------
// mbed_uart_tx_if
// Byte handshake between the producer (top-level FSM) and the transmitter.
//   tx_data  : byte to send, LSB first on the line
//   tx_valid : producer offers tx_data
//   tx_ready : transmitter can accept a byte this cycle
// Modports: master = producer, slave = transmitter.
// -----------------------------------------------------------------------------
interface mbed_uart_tx_if;
    import mbed_uart_tx_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/mbed_uart_tx_byte_fifo.sv
// -----------------------------------------------------------------------------
// mbed_uart_tx_byte_fifo
// Synchronous byte FIFO with show-ahead read data.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   push_i/wdata_i: write a byte (ignored while full)
//   pop_i/rdata_o : rdata_o is the head; pop_i removes it (ignored while empty)
//   full_o, empty_o, count_o : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module mbed_uart_tx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [7:0]               wdata_i,
    input  logic                     pop_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage array: data only, no reset needed since reads are gated by count.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mbed_uart_tx.sv
// -----------------------------------------------------------------------------
// mbed_uart_tx
// 8N1 serial transmitter for the serial_return link back to the mbed.
// Bytes from the top-level FSM are buffered in a small FIFO and sent LSB first.
//   clk50m        : system clock
//   reset_n       : asynchronous active-low reset
//   tx_if         : tx_data / tx_valid / tx_ready handshake (slave side)
//   serial_return : serial line, idle high, driven straight from a flop
//   busy          : frame in progress or bytes still buffered
//   fifo_count    : bytes currently buffered
// -----------------------------------------------------------------------------
module mbed_uart_tx
    import mbed_uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk50m,
    input  logic                          reset_n,
    mbed_uart_tx_if.slave                 tx_if,
    output logic                          serial_return,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int             DIV      = calc_div(CLK_HZ, BAUD);
    localparam int             CNT_W    = $clog2(DIV);
    localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e                 state_q;
    logic [CNT_W-1:0]          baud_cnt_q;
    logic [2:0]                bit_idx_q;
    logic [DATA_BITS-1:0]      shift_q;
    logic                      line_q;

    logic                      push_s;
    logic                      pop_s;
    logic                      full_s;
    logic                      empty_s;
    logic                      wrap_s;
    logic [DATA_BITS-1:0]      head_s;

    // A full FIFO refuses the push even if a pop happens in the same cycle.
    assign tx_if.tx_ready = !full_s;
    assign push_s         = tx_if.tx_valid && !full_s;
    assign wrap_s         = (baud_cnt_q == CNT_W'(DIV - 1));
    assign serial_return  = line_q;
    assign busy           = (state_q != ST_IDLE) || (fifo_count != '0);

    mbed_uart_tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk50m),
        .rst_ni  (reset_n),
        .push_i  (push_s),
        .wdata_i (tx_if.tx_data),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (fifo_count)
    );

    // Pop decision: from IDLE at once, or at the end of a stop bit for gapless frames.
    always_comb begin
        pop_s = 1'b0;
        case (state_q)
            ST_IDLE: pop_s = !empty_s;
            ST_STOP: pop_s = wrap_s && !empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Frame FSM with baud counter, shift register and registered line output.
    // The line flop follows the state one cycle later, so every bit keeps DIV cycles.
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= {CNT_W{1'b0}};
            bit_idx_q  <= 3'd0;
            shift_q    <= {DATA_BITS{1'b0}};
            line_q     <= STOP_LEVEL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    line_q <= STOP_LEVEL;
                    if (pop_s) begin
                        shift_q    <= head_s;
                        baud_cnt_q <= {CNT_W{1'b0}};
                        bit_idx_q  <= 3'd0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    line_q <= START_LEVEL;
                    if (wrap_s) begin
                        baud_cnt_q <= {CNT_W{1'b0}};
                        bit_idx_q  <= 3'd0;
                        state_q    <= ST_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    line_q <= shift_q[0];
                    if (wrap_s) begin
                        baud_cnt_q <= {CNT_W{1'b0}};
                        shift_q    <= shift_q >> 1;
                        bit_idx_q  <= bit_idx_q + 3'd1;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    line_q <= STOP_LEVEL;
                    if (wrap_s) begin
                        baud_cnt_q <= {CNT_W{1'b0}};
                        if (pop_s) begin
                            shift_q   <= head_s;
                            bit_idx_q <= 3'd0;
                            state_q   <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    line_q  <= STOP_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbed_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mbed_uart_tx
// Directed bench for mbed_uart_tx at CLK_HZ=1000, BAUD=100 (DIV=10), depth 4.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mbed_uart_tx;

    logic       clk50m  = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_return;
    logic       busy;
    logic [2:0] fifo_count;
    int         cyc     = 0;
    int         n_cmp   = 0;
    int         n_fail  = 0;

    mbed_uart_tx_if tx_if ();

    mbed_uart_tx #(
        .CLK_HZ     (1000),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk50m        (clk50m),
        .reset_n       (reset_n),
        .tx_if         (tx_if.slave),
        .serial_return (serial_return),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    always #5 clk50m = ~clk50m;

    always @(posedge clk50m) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic [9:0] wave;   // bit k = line level during bit period k (k=0 is start)
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial decoder: waits for a start bit, samples mid-bit, returns at mid-stop.
    task automatic rx_frame(output logic [7:0] d, output int t_start, output bit ok);
        int n;
        n = 0;
        d = 8'h00;
        t_start = -1;
        ok = 1'b1;
        while (serial_return !== 1'b0 && n < 3000) begin
            @(negedge clk50m);
            n++;
        end
        if (n >= 3000) begin
            ok = 1'b0;
            return;
        end
        t_start = cyc;
        repeat (5) @(negedge clk50m);
        if (serial_return !== 1'b0) ok = 1'b0;
        for (int b = 0; b < 8; b++) begin
            repeat (10) @(negedge clk50m);
            d[b] = serial_return;
        end
        repeat (10) @(negedge clk50m);
        if (serial_return !== 1'b1) ok = 1'b0;
    endtask

    initial begin
        int          e1;
        int          bad;
        int          lows;
        logic [7:0]  rd;
        int          ts;
        int          ts_prev;
        bit          ok;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};

        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk50m);
        check("reset_line",  32'(serial_return), 32'd1);
        check("reset_ready", 32'(tx_if.tx_ready), 32'd1);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_count", 32'(fifo_count), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk50m);

        // Single-byte frames from the vector table
        for (int v = 0; v < 5; v++) begin
            tx_if.tx_data  = vecs[v].data;
            tx_if.tx_valid = 1'b1;
            @(negedge clk50m);                 // edge N: accepted
            tx_if.tx_valid = 1'b0;
            check("single_count", 32'(fifo_count), 32'd1);
            @(negedge clk50m);                 // edge N+1: pop, line still idle
            check("single_n1_high", 32'(serial_return), 32'd1);
            @(negedge clk50m);                 // edge N+2: start bit
            for (int p = 0; p < 10; p++) begin
                bad = 0;
                for (int c = 0; c < 10; c++) begin
                    if (serial_return !== vecs[v].wave[p]) bad++;
                    if (p == 5 && c == 0) check("single_busy_mid", 32'(busy), 32'd1);
                    @(negedge clk50m);
                end
                check($sformatf("single_%0h_bit%0d_bad_cycles", vecs[v].data, p), 32'(bad), 32'd0);
            end
            check("single_busy_after", 32'(busy), 32'd0);
            check("single_line_after", 32'(serial_return), 32'd1);
            repeat (3) @(negedge clk50m);
        end

        // Back-to-back: 0x00 then 0xFF on consecutive edges
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b1;
        @(negedge clk50m);
        tx_if.tx_data  = 8'hFF;
        @(negedge clk50m);
        tx_if.tx_valid = 1'b0;
        rx_frame(rd, ts_prev, ok);
        check("b2b_frame0_ok", 32'(ok), 32'd1);
        check("b2b_frame0_data", 32'(rd), 32'h00);
        rx_frame(rd, ts, ok);
        check("b2b_frame1_ok", 32'(ok), 32'd1);
        check("b2b_frame1_data", 32'(rd), 32'hFF);
        check("b2b_spacing", 32'(ts - ts_prev), 32'd100);
        repeat (10) @(negedge clk50m);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Full FIFO with held valid, push-while-full with simultaneous pop
        e1 = 0;
        fork
            begin
                tx_if.tx_valid = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    tx_if.tx_data = 8'(i + 1);
                    check("full_ready_fill", 32'(tx_if.tx_ready), 32'd1);
                    if (i == 0) e1 = cyc + 1;
                    @(negedge clk50m);
                end
                check("full_count4", 32'(fifo_count), 32'd4);
                check("full_ready0", 32'(tx_if.tx_ready), 32'd0);
                tx_if.tx_data = 8'h06;
                while (cyc < e1 + 100) @(negedge clk50m);
                check("full_hold_ready0", 32'(tx_if.tx_ready), 32'd0);
                check("full_hold_count4", 32'(fifo_count), 32'd4);
                @(negedge clk50m);             // pop at end of first stop bit, push refused
                check("full_pop_count3", 32'(fifo_count), 32'd3);
                check("full_pop_ready1", 32'(tx_if.tx_ready), 32'd1);
                @(negedge clk50m);             // held byte accepted now
                check("full_accept_count4", 32'(fifo_count), 32'd4);
                tx_if.tx_valid = 1'b0;
            end
            begin
                ts_prev = 0;
                for (int f = 0; f < 6; f++) begin
                    logic [7:0] fd;
                    int         ft;
                    bit         fok;
                    rx_frame(fd, ft, fok);
                    check($sformatf("full_frame%0d_ok", f), 32'(fok), 32'd1);
                    check($sformatf("full_frame%0d_data", f), 32'(fd), 32'(f + 1));
                    if (f > 0) check($sformatf("full_frame%0d_spacing", f), 32'(ft - ts_prev), 32'd100);
                    ts_prev = ft;
                end
            end
        join
        repeat (10) @(negedge clk50m);
        check("full_done_busy", 32'(busy), 32'd0);
        check("full_done_count", 32'(fifo_count), 32'd0);

        // Reset mid-frame during bit 4 of 0xE5 (d4 = 0) with 3 bytes buffered
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'hE5;
        e1 = cyc + 1;
        @(negedge clk50m);
        tx_if.tx_data  = 8'h22;
        @(negedge clk50m);
        tx_if.tx_data  = 8'h33;
        @(negedge clk50m);
        tx_if.tx_data  = 8'h44;
        @(negedge clk50m);
        tx_if.tx_valid = 1'b0;
        check("rst_mid_buffered", 32'(fifo_count), 32'd3);
        while (cyc < e1 + 55) @(negedge clk50m);
        check("rst_mid_line_low_before", 32'(serial_return), 32'd0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_line", 32'(serial_return), 32'd1);
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(tx_if.tx_ready), 32'd1);
        repeat (3) @(negedge clk50m);
        reset_n = 1'b1;
        lows = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk50m);
            if (serial_return !== 1'b1) lows++;
        end
        check("rst_mid_no_resend", 32'(lows), 32'd0);
        check("rst_mid_busy_after", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
